ifu_pcgen: RTL and testbench
============================

IFU_PCGEN -- requirements
Module: ifu_pcgen

Interface
REQ-001 Parameter/define: `PC_RESET_VEC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter/define: `PC_SIZE, default 32, PC width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 pcgen_i_flush_req  in  1  flush/redirect request from commit (bjp needflush path).
REQ-006 pcgen_i_flush_pc  in  PC_SIZE  redirect target.
REQ-007 pcgen_o_flush_ack  out  1  flush accepted this cycle.
REQ-008 pcgen_i_halt  in  1  suppress new fetch issue (debug/wfi).
REQ-009 pcgen_o_req_valid  out  1  fetch request valid.
REQ-010 pcgen_i_req_ready  in  1  fetch port accepts request.
REQ-011 pcgen_o_req_pc  out  PC_SIZE  fetch address.
REQ-012 pcgen_i_rsp_valid  in  1  fetch response returned.
REQ-013 pcgen_i_rsp_rv32  in  1  returned instruction is 32-bit (1) or 16-bit (0).
REQ-014 pcgen_o_ir_valid  out  1  one-cycle pulse: non-killed instruction delivered to decode.
REQ-015 pcgen_o_pc_r  out  PC_SIZE  PC of last delivered instruction (feeds bjp pc input).

Function
REQ-016 States: ISSUE (no fetch outstanding), WAIT (one fetch outstanding), KILL (one fetch outstanding, result to be dropped); max one outstanding fetch.
REQ-017 Registers: state, nxt_pc (next fetch address), out_pc (address of outstanding fetch), pc_r.
REQ-018 ISSUE: req_valid = ~halt & ~flush_req; req_pc = nxt_pc; on req_valid & req_ready: out_pc <= nxt_pc, -> WAIT.
REQ-019 WAIT, rsp_valid & ~flush_req: ir_valid=1, pc_r <= out_pc, nxt_pc <= out_pc + (rsp_rv32 ? 4 : 2), -> ISSUE.
REQ-020 flush_ack = flush_req in every state (flush always accepted in the same cycle, zero latency).
REQ-021 Accepted flush: nxt_pc <= {flush_pc[PC_SIZE-1:1],1'b0} (bit 0 forced zero).
REQ-022 Flush in ISSUE: request suppressed that cycle, stay ISSUE; redirect fetch issued next cycle at earliest.
REQ-023 Flush in WAIT without rsp_valid: -> KILL.
REQ-024 Flush in WAIT with rsp_valid same cycle: response dropped (ir_valid=0, pc_r unchanged), -> ISSUE.
REQ-025 KILL: rsp_valid drops response (ir_valid=0), -> ISSUE; further flushes overwrite nxt_pc (latest wins).
REQ-026 Halt has no effect on WAIT/KILL; outstanding response still completes/drops.
REQ-027 PC arithmetic modulo 2^PC_SIZE; wrap-around from 32'hFFFF_FFFE +2 yields 0, no error.
REQ-028 ir_valid never asserted in ISSUE or KILL.

Reset
REQ-029 On rst_n low (async): state=ISSUE, nxt_pc=`PC_RESET_VEC, out_pc=`PC_RESET_VEC, pc_r=`PC_RESET_VEC.
REQ-030 During reset all outputs: req_valid=0, flush_ack=0, ir_valid=0, req_pc=`PC_RESET_VEC.
REQ-031 Reset mid-fetch: outstanding fetch forgotten; fetch port is reset together with this block.
REQ-032 First req_valid in first cycle after rst_n deasserts, address `PC_RESET_VEC (unless halt/flush).

Structure
REQ-033 `PC_SIZE, `PC_RESET_VEC and state encodings (2-bit) live in mcu_defines.v.
REQ-034 Single flat module; no sub-module; state register one-hot or binary at implementer's choice.

Verification
REQ-035 Reset, ready=1, rsp 1 cycle later rv32=1 x3 -> req_pc 0x0,0x4,0x8; pc_r 0x0,0x4,0x8 with ir_valid pulses.
REQ-036 Mixed: rsp rv32=0 at 0x0 then rv32=1 -> next req_pc 0x2 then 0x6.
REQ-037 Flush pc=0x101 while WAIT on 0x8 -> ack same cycle, KILL, response at 0x8 dropped, next req_pc 0x100.
REQ-038 Flush 0x200 and rsp_valid same cycle -> no ir_valid, next req_pc 0x200; second flush 0x300 in KILL -> req_pc 0x300.
REQ-039 halt=1 in ISSUE for 5 cycles with req_ready=1 -> req_valid=0 throughout; flush 0x40 accepted; halt=0 -> req_pc 0x40.
REQ-040 rst_n asserted mid-WAIT -> immediate req_valid=0, pc_r=`PC_RESET_VEC; after release req_pc=`PC_RESET_VEC.

Source files
------------

// File: rtl/ifu_pcgen_pkg.sv
// Shared definitions for the fetch PC generator: PC width,
// reset vector and the 2-bit fetch-state encoding.
package ifu_pcgen_pkg;

    localparam int unsigned PC_SIZE = 32;
    localparam logic [PC_SIZE-1:0] PC_RESET_VEC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_KILL  = 2'd2
    } pcgen_state_e;

endpackage

// File: rtl/ifu_pcgen.sv
// Fetch PC generator: issues one fetch at a time, advances the PC by
// the returned instruction size and redirects on flush from commit.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   pcgen_i_flush_req/pc  redirect request and target
//   pcgen_o_flush_ack     redirect accepted (always, same cycle)
//   pcgen_i_halt          hold off new fetch issue
//   pcgen_o_req_*         fetch request handshake and address
//   pcgen_i_rsp_*         fetch response and its size (rv32 / rv16)
//   pcgen_o_ir_valid      delivered-instruction pulse to decode
//   pcgen_o_pc_r          PC of the last delivered instruction
module ifu_pcgen
    import ifu_pcgen_pkg::*;
#(
    parameter int unsigned          W     = PC_SIZE,
    parameter logic [PC_SIZE-1:0]   RSTVEC = PC_RESET_VEC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pcgen_i_flush_req,
    input  logic [W-1:0] pcgen_i_flush_pc,
    output logic         pcgen_o_flush_ack,
    input  logic         pcgen_i_halt,
    output logic         pcgen_o_req_valid,
    input  logic         pcgen_i_req_ready,
    output logic [W-1:0] pcgen_o_req_pc,
    input  logic         pcgen_i_rsp_valid,
    input  logic         pcgen_i_rsp_rv32,
    output logic         pcgen_o_ir_valid,
    output logic [W-1:0] pcgen_o_pc_r
);

    localparam logic [W-1:0] RST_PC = RSTVEC[W-1:0];

    pcgen_state_e state_q, state_d;
    logic [W-1:0] nxt_pc_q, nxt_pc_d;
    logic [W-1:0] out_pc_q, out_pc_d;
    logic [W-1:0] pc_r_q,   pc_r_d;
    logic         req_valid;
    logic         ir_valid;
    logic [W-1:0] step;

    assign step = pcgen_i_rsp_rv32 ? W'(4) : W'(2);

    always_comb begin
        state_d   = state_q;
        nxt_pc_d  = nxt_pc_q;
        out_pc_d  = out_pc_q;
        pc_r_d    = pc_r_q;
        req_valid = 1'b0;
        ir_valid  = 1'b0;

        unique case (state_q)
            ST_ISSUE: begin
                req_valid = ~pcgen_i_halt & ~pcgen_i_flush_req;
                if (req_valid && pcgen_i_req_ready) begin
                    out_pc_d = nxt_pc_q;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (pcgen_i_rsp_valid) begin
                    state_d = ST_ISSUE;
                    if (!pcgen_i_flush_req) begin
                        ir_valid = 1'b1;
                        pc_r_d   = out_pc_q;
                        nxt_pc_d = out_pc_q + step;
                    end
                end else if (pcgen_i_flush_req) begin
                    state_d = ST_KILL;
                end
            end
            ST_KILL: begin
                if (pcgen_i_rsp_valid) begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_ISSUE;
        endcase

        // Redirect target overrides any sequential advance; latest wins.
        if (pcgen_i_flush_req) begin
            nxt_pc_d = {pcgen_i_flush_pc[W-1:1], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ISSUE;
            nxt_pc_q <= RST_PC;
            out_pc_q <= RST_PC;
            pc_r_q   <= RST_PC;
        end else begin
            state_q  <= state_d;
            nxt_pc_q <= nxt_pc_d;
            out_pc_q <= out_pc_d;
            pc_r_q   <= pc_r_d;
        end
    end

    // Outputs are gated while reset is held so nothing leaks to the
    // fetch port or decode from inputs that are still toggling.
    assign pcgen_o_req_valid = req_valid & rst_n;
    assign pcgen_o_flush_ack = pcgen_i_flush_req & rst_n;
    assign pcgen_o_ir_valid  = ir_valid & rst_n;
    assign pcgen_o_req_pc    = nxt_pc_q;
    assign pcgen_o_pc_r      = pc_r_q;

endmodule

// File: tb/tb_ifu_pcgen.sv
// Self-checking bench for ifu_pcgen: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_ifu_pcgen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_req = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        flush_ack;
    logic        halt = 1'b0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_pc;
    logic        rsp_valid = 1'b0;
    logic        rsp_rv32 = 1'b0;
    logic        ir_valid;
    logic [31:0] pc_r;

    int n_chk = 0;
    int n_fail = 0;

    // Model: a fetch is either absent, pending, or pending-but-doomed.
    bit          m_pending;
    bit          m_doomed;
    logic [31:0] m_next;
    logic [31:0] m_fetch_pc;
    logic [31:0] m_last;
    logic [31:0] obs_req_pc;
    logic        obs_req_valid;
    logic        obs_ir_valid;

    always #5 clk = ~clk;

    ifu_pcgen dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pcgen_i_flush_req (flush_req),
        .pcgen_i_flush_pc  (flush_pc),
        .pcgen_o_flush_ack (flush_ack),
        .pcgen_i_halt      (halt),
        .pcgen_o_req_valid (req_valid),
        .pcgen_i_req_ready (req_ready),
        .pcgen_o_req_pc    (req_pc),
        .pcgen_i_rsp_valid (rsp_valid),
        .pcgen_i_rsp_rv32  (rsp_rv32),
        .pcgen_o_ir_valid  (ir_valid),
        .pcgen_o_pc_r      (pc_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pending  = 0;
        m_doomed   = 0;
        m_next     = 32'h0;
        m_fetch_pc = 32'h0;
        m_last     = 32'h0;
    endtask

    // One clock cycle: apply inputs, check outputs, advance the model.
    task automatic step(input bit h, input bit f, input logic [31:0] fpc,
                        input bit rdy, input bit rv, input bit r32);
        bit e_rv, e_ir, issued;
        halt = h; flush_req = f; flush_pc = fpc;
        req_ready = rdy; rsp_valid = rv; rsp_rv32 = r32;
        #1;
        e_rv = !m_pending && !h && !f;
        e_ir = m_pending && !m_doomed && rv && !f;
        chk("req_valid", {31'b0, req_valid}, {31'b0, e_rv});
        chk("req_pc", req_pc, m_next);
        chk("flush_ack", {31'b0, flush_ack}, {31'b0, f});
        chk("ir_valid", {31'b0, ir_valid}, {31'b0, e_ir});
        chk("pc_r", pc_r, m_last);
        obs_req_pc = req_pc;
        obs_req_valid = req_valid;
        obs_ir_valid = ir_valid;
        @(posedge clk);
        issued = e_rv && rdy;
        if (issued) begin
            m_pending  = 1;
            m_doomed   = 0;
            m_fetch_pc = m_next;
        end else if (m_pending && rv) begin
            if (e_ir) begin
                m_last = m_fetch_pc;
                m_next = m_fetch_pc + (r32 ? 32'd4 : 32'd2);
            end
            m_pending = 0;
            m_doomed  = 0;
        end else if (m_pending && f) begin
            m_doomed = 1;
        end
        if (f) m_next = fpc & ~32'h1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        flush_req = 1'b1;
        halt = 1'b0;
        req_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_req_valid", {31'b0, req_valid}, 32'h0);
        chk("rst_flush_ack", {31'b0, flush_ack}, 32'h0);
        chk("rst_ir_valid", {31'b0, ir_valid}, 32'h0);
        chk("rst_pc_r", pc_r, 32'h0);
        chk("rst_req_pc", req_pc, 32'h0);
        repeat (2) @(negedge clk);
        flush_req = 1'b0;
        rst_n = 1'b1;
    endtask

    // Issue a fetch and return it one cycle later.
    task automatic fetch(input bit r32);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, r32);
    endtask

    initial begin
        logic [31:0] t;
        model_reset();
        do_reset();

        // Three sequential 32-bit fetches.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0, 0);
            t = 32'(i * 4);
            chk("seq_req_pc", obs_req_pc, t);
            step(0, 0, 0, 0, 1, 1);
            chk("seq_ir", {31'b0, obs_ir_valid}, 32'h1);
            chk("seq_pc_r", pc_r, t);
        end

        // Mixed sizes: 16-bit then 32-bit.
        do_reset();
        fetch(0);
        step(0, 0, 0, 1, 0, 0);
        chk("mix_pc2", obs_req_pc, 32'h2);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0, 0);
        chk("mix_pc6", obs_req_pc, 32'h6);
        step(0, 0, 0, 0, 1, 1);

        // Flush while waiting on 0x8 kills that response.
        do_reset();
        fetch(1);
        fetch(1);
        step(0, 0, 0, 1, 0, 0);
        chk("kill_src", obs_req_pc, 32'h8);
        step(0, 1, 32'h101, 1, 0, 0);
        step(0, 0, 0, 1, 1, 1);
        chk("kill_drop", {31'b0, obs_ir_valid}, 32'h0);
        chk("kill_pc_r", pc_r, 32'h4);
        step(0, 0, 0, 1, 0, 0);
        chk("kill_redir", obs_req_pc, 32'h100);

        // Flush coincident with response, then flush inside KILL.
        step(0, 1, 32'h200, 1, 1, 1);
        chk("coinc_drop", {31'b0, obs_ir_valid}, 32'h0);
        step(0, 0, 0, 1, 0, 0);
        chk("coinc_redir", obs_req_pc, 32'h200);
        step(0, 1, 32'h250, 1, 0, 0);
        step(0, 1, 32'h300, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        chk("kill2_drop", {31'b0, obs_ir_valid}, 32'h0);
        step(0, 0, 0, 1, 0, 0);
        chk("kill2_redir", obs_req_pc, 32'h300);
        step(0, 0, 0, 0, 1, 1);

        // Halt holds off issue; flush during halt is still taken.
        for (int i = 0; i < 5; i++) begin
            step(1, i == 2, 32'h40, 1, 0, 0);
            chk("halt_rv", {31'b0, obs_req_valid}, 32'h0);
        end
        step(0, 0, 0, 1, 0, 0);
        chk("halt_redir", obs_req_pc, 32'h40);

        // Reset while a fetch is outstanding.
        do_reset();
        step(0, 0, 0, 1, 0, 0);
        chk("rst_again", obs_req_pc, 32'h0);

        // Wrap-around at the top of the address space.
        step(0, 0, 0, 0, 1, 1);
        step(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("wrap_src", obs_req_pc, 32'hFFFF_FFFE);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("wrap_dst", obs_req_pc, 32'h0);

        // Randomized traffic; responses only while a fetch is pending.
        for (int i = 0; i < 400; i++) begin
            bit rv;
            rv = m_pending && ($urandom_range(1, 0) == 1);
            step($urandom_range(3, 0) == 0,
                 $urandom_range(7, 0) == 0,
                 $urandom,
                 $urandom_range(1, 0) == 1,
                 rv,
                 $urandom_range(1, 0) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
